// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/branch-flush/mem-freeze pipeline hazard control; outputs pc_hold, ifid_hold, idex_bubble, ifid_flush, freeze plus saturating stall/flush counters
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instruction,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;
  state_t state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  logic use1, use2, load_use, br, in_flush, unused_bits;
  assign op = id_instruction[6:0];
  assign rs1 = id_instruction[19:15];
  assign rs2 = id_instruction[24:20];
  assign unused_bits = ^{id_instruction[31:25], id_instruction[14:7]};
  assign use1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign use2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign load_use = ex_mem_read && ex_rd != 5'd0 && ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
  assign br = branch_taken && !mem_busy;
  // leaving MEM_WAIT resumes the flush window if one was interrupted
  assign in_flush = state_q == FLUSH || (state_q == MEM_WAIT && fcnt_q != 4'd0);
  always_comb begin
    freeze = !rst && mem_busy;
    ifid_flush = !rst && !mem_busy && (br || in_flush);
    pc_hold = !rst && (mem_busy || (!br && !in_flush && load_use));
    ifid_hold = pc_hold;
    idex_bubble = !rst && !mem_busy && (br || (!in_flush && load_use));
    state_d = mem_busy ? MEM_WAIT : br ? (FLUSH_CYCLES == 1 ? RUN : FLUSH) :
              (in_flush && fcnt_q != 4'd1) ? FLUSH : RUN;
    fcnt_d = mem_busy ? fcnt_q : br ? 4'(FLUSH_CYCLES - 1) : in_flush ? fcnt_q - 4'd1 : 4'd0;
    stall_d = (pc_hold && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (br && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
endmodule
